// File: rtl/sdram_lcd_reader.sv
// sdram_lcd_reader
//
// Display scan-out stage fed by the SDRAM controller's read FIFO. Generates
// VGA/LCD raster timing and pops one RGB565 pixel from the FIFO for each
// active pixel clock once the memory is initialised, the FIFO holds data, and
// a new frame begins. Runs entirely in the FIFO read clock domain.
//
// Ports:
//   clk            pixel clock (same net as the FIFO read clock)
//   rst            synchronous reset, active-high
//   init_done      SDRAM initialisation complete
//   rfifo_rd_ready FIFO holds enough data to stream
//   rfifo_rd_en    FIFO pop; data appears on rfifo_rd_data one cycle later
//   rfifo_rd_data  FIFO output, RGB565
//   lcd_hs/lcd_vs  horizontal/vertical sync (active level SYNC_POL)
//   lcd_de         data enable
//   lcd_rgb        pixel, forced to 0 outside lcd_de
//   frame_start    one-cycle pulse at the first pixel fetch of a frame
//   fifo_err       sticky underflow flag (pop while FIFO not ready)
module sdram_lcd_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        rfifo_rd_ready,
  output logic        rfifo_rd_en,
  input  logic [15:0] rfifo_rd_data,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start,
  output logic        fifo_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {
    WAIT_INIT,
    WAIT_DATA,
    WAIT_FRAME,
    RUN
  } state_t;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  state_t        state_q, state_d;
  logic          lcd_hs_q, lcd_hs_d;
  logic          lcd_vs_q, lcd_vs_d;
  logic          lcd_de_q, lcd_de_d;
  logic          fifo_err_q, fifo_err_d;

  logic h_last, v_last, active, hs_act, vs_act;

  // Stage-0 decodes straight from the registered counters. Comparisons are
  // done in int so sync windows ending exactly at the line/frame total cannot
  // overflow the counter width.
  always_comb begin
    h_last = (int'(h_cnt_q) == H_TOTAL - 1);
    v_last = (int'(v_cnt_q) == V_TOTAL - 1);
    active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    hs_act = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
             (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    vs_act = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
             (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
  end

  // Pops and the frame marker come straight off registered state so the FIFO
  // sees the request in the same cycle the raster position is valid.
  assign rfifo_rd_en = active && (state_q == RUN);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0) && (state_q == RUN);

  always_comb begin
    // Counters free-run in every state to keep the monitor locked.
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end

    state_d = state_q;
    if (!init_done) begin
      state_d = WAIT_INIT;
    end else begin
      unique case (state_q)
        WAIT_INIT:  state_d = WAIT_DATA;
        WAIT_DATA:  if (rfifo_rd_ready) state_d = WAIT_FRAME;
        // Leave on the last position so RUN starts exactly at (0,0).
        WAIT_FRAME: if (h_last && v_last) state_d = RUN;
        RUN:        state_d = RUN;
        default:    state_d = WAIT_INIT;
      endcase
    end

    lcd_hs_d   = hs_act ? SYNC_POL : ~SYNC_POL;
    lcd_vs_d   = vs_act ? SYNC_POL : ~SYNC_POL;
    lcd_de_d   = rfifo_rd_en;
    fifo_err_d = fifo_err_q || (rfifo_rd_en && !rfifo_rd_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      state_q    <= WAIT_INIT;
      lcd_hs_q   <= ~SYNC_POL;
      lcd_vs_q   <= ~SYNC_POL;
      lcd_de_q   <= 1'b0;
      fifo_err_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      state_q    <= state_d;
      lcd_hs_q   <= lcd_hs_d;
      lcd_vs_q   <= lcd_vs_d;
      lcd_de_q   <= lcd_de_d;
      fifo_err_q <= fifo_err_d;
    end
  end

  assign lcd_hs   = lcd_hs_q;
  assign lcd_vs   = lcd_vs_q;
  assign lcd_de   = lcd_de_q;
  assign fifo_err = fifo_err_q;
  // FIFO read latency is one cycle, the same as the lcd_de register, so the
  // raw FIFO output lines up with lcd_de without another pipeline stage.
  assign lcd_rgb  = lcd_de_q ? rfifo_rd_data : 16'h0000;

endmodule

// File: tb/tb_sdram_lcd_reader.sv
// tb_sdram_lcd_reader
//
// Directed sequence with randomised timing and pixel data for
// sdram_lcd_reader, using the small raster (14 x 7 total). The reference model
// tracks an absolute raster position (one integer, split into h/v with
// divide/modulo) plus readiness flags, and predicts every output each cycle.
module tb_sdram_lcd_reader;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int MEM_N = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        rfifo_rd_ready;
  logic        rfifo_rd_en;
  logic [15:0] rfifo_rd_data;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start, fifo_err;
  logic [15:0] lcd_rgb;

  sdram_lcd_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .init_done(init_done),
    .rfifo_rd_ready(rfifo_rd_ready),
    .rfifo_rd_en(rfifo_rd_en),
    .rfifo_rd_data(rfifo_rd_data),
    .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs),
    .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb),
    .frame_start(frame_start),
    .fifo_err(fifo_err)
  );

  always #5 clk = ~clk;

  logic [15:0] fifo_mem [MEM_N];
  int drv_idx;
  int n_cmp, n_bad, cyc;

  // Reference model
  int          m_t;          // raster position 0..FT-1, h = t%HT, v = t/HT
  bit          m_init_ok;    // init_done seen at an edge, not dropped since
  bit          m_data_ok;    // FIFO readiness seen after init
  bit          m_streaming;  // a frame boundary passed after readiness
  bit          m_de, m_hs, m_vs, m_err;
  logic [15:0] m_pix;
  int          m_idx;

  function automatic bit exp_rd_en();
    return m_streaming && ((m_t % HT) < HA) && ((m_t / HT) < VA);
  endfunction

  function automatic bit exp_fs();
    return m_streaming && (m_t == 0);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rd_now;
    int h, v;
    rd_now = exp_rd_en();
    h = m_t % HT;
    v = m_t / HT;
    // The pop happens whenever the request is up, reset or not.
    if (rd_now) begin
      m_pix = fifo_mem[m_idx % MEM_N];
      m_idx++;
    end
    if (rst) begin
      m_t = 0; m_init_ok = 0; m_data_ok = 0; m_streaming = 0;
      m_de = 0; m_hs = 1; m_vs = 1; m_err = 0;
    end else begin
      m_de  = rd_now;
      m_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      m_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      m_err = m_err || (rd_now && !rfifo_rd_ready);
      if (!init_done) begin
        m_init_ok = 0; m_data_ok = 0; m_streaming = 0;
      end else if (!m_streaming) begin
        if (m_data_ok) begin
          if (m_t == FT - 1) m_streaming = 1;
        end else if (m_init_ok) begin
          if (rfifo_rd_ready) m_data_ok = 1;
        end else begin
          m_init_ok = 1;
        end
      end
      m_t = (m_t + 1) % FT;
    end
  endtask

  task automatic tick();
    bit pop;
    pop = (rfifo_rd_en === 1'b1);
    model_edge();
    @(posedge clk);
    if (pop) begin
      rfifo_rd_data = fifo_mem[drv_idx % MEM_N];
      drv_idx++;
    end
    #1;
    cyc++;
    check("rfifo_rd_en", {15'b0, rfifo_rd_en}, {15'b0, exp_rd_en()});
    check("frame_start", {15'b0, frame_start}, {15'b0, exp_fs()});
    check("lcd_de", {15'b0, lcd_de}, {15'b0, m_de});
    check("lcd_hs", {15'b0, lcd_hs}, {15'b0, m_hs});
    check("lcd_vs", {15'b0, lcd_vs}, {15'b0, m_vs});
    check("fifo_err", {15'b0, fifo_err}, {15'b0, m_err});
    check("lcd_rgb", lcd_rgb, m_de ? m_pix : 16'h0000);
  endtask

  initial begin
    bit found;
    int de_cnt, uh, lim;

    for (int i = 0; i < MEM_N; i++) begin
      fifo_mem[i] = (i < 64) ? 16'(i) : 16'($urandom);
    end
    n_cmp = 0; n_bad = 0; cyc = 0; drv_idx = 0;
    m_t = 0; m_idx = 0; m_pix = 16'h0;
    m_init_ok = 0; m_data_ok = 0; m_streaming = 0;
    m_de = 0; m_hs = 1; m_vs = 1; m_err = 0;
    rst = 1'b1; init_done = 1'b0; rfifo_rd_ready = 1'b0;
    rfifo_rd_data = 16'hDEAD;

    $display("step: reset held 3 cycles");
    repeat (3) tick();
    rst = 1'b0;

    $display("step: free-running raster, init_done at 20, ready at 30");
    repeat (20) tick();
    init_done = 1'b1;
    repeat (10) tick();
    rfifo_rd_ready = 1'b1;

    $display("step: wait for first frame_start");
    found = 0;
    for (int k = 0; k < 3 * FT && !found; k++) begin
      tick();
      if (frame_start === 1'b1) found = 1;
    end
    check("first_frame_start_seen", {15'b0, found}, 16'h0001);
    check("rd_en_at_frame_start", {15'b0, rfifo_rd_en}, 16'h0001);

    $display("step: stream one full frame and count data enables");
    de_cnt = 0;
    for (int k = 0; k < FT; k++) begin
      tick();
      if (lcd_de === 1'b1) de_cnt++;
    end
    check("de_per_frame", 16'(de_cnt), 16'(VA * HA));

    uh = int'($urandom_range(1, HA - 2));
    $display("step: underflow at active h=%0d", uh);
    found = 0;
    for (int k = 0; k < 2 * FT && !found; k++) begin
      tick();
      if (exp_rd_en() && (m_t % HT) == uh && (m_t / HT) == 1) found = 1;
    end
    check("underflow_point_seen", {15'b0, found}, 16'h0001);
    rfifo_rd_ready = 1'b0;
    tick();
    rfifo_rd_ready = 1'b1;
    check("fifo_err_rises", {15'b0, fifo_err}, 16'h0001);
    repeat (2 * FT) tick();
    check("fifo_err_sticky", {15'b0, fifo_err}, 16'h0001);

    lim = int'($urandom_range(20, 70));
    $display("step: init_done loss after %0d cycles", lim);
    repeat (lim) tick();
    init_done = 1'b0;
    tick();
    check("rd_en_off_after_init_loss", {15'b0, rfifo_rd_en}, 16'h0000);
    lim = int'($urandom_range(1, 15));
    repeat (lim) tick();
    init_done = 1'b1;
    repeat (3 * FT) tick();

    $display("step: reset pulse while lcd_de high");
    found = 0;
    for (int k = 0; k < 2 * FT && !found; k++) begin
      tick();
      if (lcd_de === 1'b1) found = 1;
    end
    check("de_high_before_reset", {15'b0, found}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_clears_fifo_err", {15'b0, fifo_err}, 16'h0000);
    check("reset_clears_de", {15'b0, lcd_de}, 16'h0000);
    repeat (3 * FT) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_lcd_reader.md
# sdram_lcd_reader

Display scan-out stage directly downstream of the SDRAM controller's read FIFO. It generates parameterised VGA/LCD raster timing and pops one 16-bit RGB565 pixel from the read FIFO per active pixel clock. It presents the pixel together with aligned sync and data-enable signals. It runs entirely in the read FIFO's read clock domain: `clk` drives `rfifo_rd_clk`.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)

- clk  in  1  pixel clock; same net as `rfifo_rd_clk`
- rst  in  1  synchronous reset, active-high
- init_done  in  1  SDRAM initialisation complete
- rfifo_rd_ready  in  1  read FIFO holds enough data to stream
- rfifo_rd_en  out  1  read FIFO pop; data is valid on the next cycle
- rfifo_rd_data  in  16  read FIFO output, RGB565
- lcd_hs  out  1  horizontal sync
- lcd_vs  out  1  vertical sync
- lcd_de  out  1  data enable
- lcd_rgb  out  16  pixel, RGB565
- frame_start  out  1  one-cycle pulse at the first pixel fetch of each streamed frame
- fifo_err  out  1  sticky underflow flag

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters are sized by $clog2 of the totals.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Both counters run freely in every state, so the monitor stays locked.
- Stage-0 decodes, taken from the counters:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Active region is first in each line and frame; blanking follows.
- FSM states:
  - WAIT_INIT: stays until init_done=1, then goes to WAIT_DATA.
  - WAIT_DATA: stays until rfifo_rd_ready=1, then goes to WAIT_FRAME.
  - WAIT_FRAME: when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, goes to RUN, so RUN begins exactly at (0,0).
  - RUN: streams continuously.
  - From any state, init_done=0 forces WAIT_INIT on the next cycle.
- rfifo_rd_en = active && state==RUN. It is combinational from registered counters and state.
- frame_start = (h_cnt==0) && (v_cnt==0) && state==RUN.
- fifo_err is set when rfifo_rd_en=1 while rfifo_rd_ready=0. It stays set until rst.
  - Streaming continues after an underflow; there is no resynchronisation.
- In states other than RUN: lcd_de=0 and lcd_rgb=0, while syncs keep toggling.

## Timing
- Output stage: one register stage after stage-0.
  - lcd_hs = hs_act ? SYNC_POL : ~SYNC_POL
  - lcd_vs = vs_act ? SYNC_POL : ~SYNC_POL
  - lcd_de = registered rfifo_rd_en
  - lcd_rgb = lcd_de ? rfifo_rd_data : 0
- lcd_rgb is combinational from lcd_de and the FIFO output. It is aligned because the FIFO has one-cycle read latency.
- Latency: counter position (h,v) appears on the lcd_* outputs one clock later.
- The first lcd_de of a frame is one cycle after frame_start.
- Reset values:
  - h_cnt=0, v_cnt=0, state=WAIT_INIT
  - rfifo_rd_en=0, lcd_de=0, lcd_rgb=0, frame_start=0, fifo_err=0
  - lcd_hs and lcd_vs at the inactive level (~SYNC_POL)
- rst mid-frame: on the next edge every register returns to its reset value and the counters restart at (0,0).
  - The FIFO is not flushed by this block.
- init_done and rfifo_rd_ready asserted in the same cycle while in WAIT_INIT: only one state advance per clock, to WAIT_DATA.
- rfifo_rd_ready is sampled only in WAIT_DATA (for gating) and during reads (for fifo_err).

## Test plan
Small parameters for simulation: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, so H_TOTAL=14 and V_TOTAL=7.

- Reset and counters: hold rst for 3 cycles, then release with init_done=0.
  - lcd_hs and lcd_vs read 1, lcd_de=0, rfifo_rd_en=0.
  - lcd_hs goes low for 2 clocks of every 14, starting 11 clocks after h_cnt=0 (10 plus the output stage).
  - lcd_vs goes low for one line of every 7.
- Startup gating: assert init_done at cycle 20 and rfifo_rd_ready at cycle 30.
  - No rfifo_rd_en before the first (0,0) after cycle 30.
  - frame_start pulses exactly once there, and rfifo_rd_en is high in that cycle.
- Streaming: the FIFO model returns an incrementing count starting at 0x0000.
  - Per frame, lcd_de is high for 32 clocks in 4 bursts of 8.
  - lcd_rgb equals 0x0000..0x001F in order.
  - lcd_rgb is 0 whenever lcd_de=0.
- Underflow: drop rfifo_rd_ready for one cycle mid-line during RUN.
  - fifo_err rises on the next clock and stays high across the following frames.
  - lcd_de keeps its pattern.
- init_done loss: deassert init_done mid-frame.
  - rfifo_rd_en=0 from the next cycle and lcd_de=0 one cycle after.
  - Re-asserting init_done with rfifo_rd_ready=1 resumes streaming only at the next (0,0).
- Reset mid-RUN: pulse rst while lcd_de=1.
  - All outputs take their reset values on the next edge, including fifo_err=0.
  - The counters restart at (0,0).
